capture_ctrl: RTL

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/capture_ctrl.sv
// Capture sequencer for a circular sample RAM: decimated write strobes, pre-trigger
// arming, post-trigger countdown and the oldest-sample pointer used for the dump.
module capture_ctrl #(
   parameter int ENTRIES      = 384,
   parameter int LOG2_ENTRIES = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic [3:0]              decimator,
   input  logic [LOG2_ENTRIES-1:0] trig_pos,
   input  logic                    triggered,
   output logic                    armed,
   output logic                    we,
   output logic [LOG2_ENTRIES-1:0] waddr,
   output logic                    set_capture_done,
   output logic [LOG2_ENTRIES-1:0] start_addr,
   output logic                    capturing
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int                    CW        = LOG2_ENTRIES + 1;
   localparam logic [LOG2_ENTRIES-1:0] LAST_ADDR = LOG2_ENTRIES'(ENTRIES - 1);
   localparam logic [CW-1:0]           FULL      = CW'(ENTRIES);

   state_t                  state, state_d;
   logic [15:0]             dec_cnt, dec_cnt_d, dec_mask;
   logic [CW-1:0]           smpl_cnt, smpl_cnt_d, arm_level;
   logic [LOG2_ENTRIES-1:0] post_cnt, post_cnt_d;
   logic [LOG2_ENTRIES-1:0] waddr_d, start_addr_d, tp;
   logic                    trig_seen, trig_seen_d, armed_d;
   logic                    sample_tick, done_hit;

   assign tp        = (trig_pos > LAST_ADDR) ? LAST_ADDR : trig_pos;
   assign arm_level = FULL - {1'b0, tp};
   assign dec_mask  = (16'd1 << decimator) - 16'd1;

   // >= rather than == so that shrinking the decimator below the running count
   // still produces the next strobe immediately instead of waiting for a 16-bit wrap.
   assign sample_tick = (dec_cnt >= dec_mask);
   assign done_hit    = trig_seen && (post_cnt == tp);

   // NOTE: every signal written here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d          = state;
      dec_cnt_d        = dec_cnt;
      smpl_cnt_d       = smpl_cnt;
      post_cnt_d       = post_cnt;
      trig_seen_d      = trig_seen;
      armed_d          = armed;
      waddr_d          = waddr;
      start_addr_d     = start_addr;
      we               = 1'b0;
      set_capture_done = 1'b0;
      capturing        = 1'b0;

      case (state)
         IDLE: begin
            dec_cnt_d   = '0;
            smpl_cnt_d  = '0;
            post_cnt_d  = '0;
            trig_seen_d = 1'b0;
            armed_d     = 1'b0;
            if (run) state_d = CAPTURE;
         end

         CAPTURE: begin
            capturing = 1'b1;
            if (!run) begin
               // abort: nothing written, no done pulse, start_addr untouched
               state_d = IDLE;
               armed_d = 1'b0;
            end else if (done_hit) begin
               set_capture_done = 1'b1;
               start_addr_d     = waddr;
               armed_d          = 1'b0;
               state_d          = DONE;
            end else begin
               if (sample_tick) begin
                  we        = 1'b1;
                  dec_cnt_d = '0;
                  waddr_d   = (waddr == LAST_ADDR) ? '0 : waddr + LOG2_ENTRIES'(1);
                  if (smpl_cnt != FULL) smpl_cnt_d = smpl_cnt + CW'(1);
                  if (trig_seen) post_cnt_d = post_cnt + LOG2_ENTRIES'(1);
               end else begin
                  dec_cnt_d = dec_cnt + 16'd1;
               end
               if (smpl_cnt >= arm_level) armed_d = 1'b1;
               if (armed && triggered) trig_seen_d = 1'b1;
            end
         end

         DONE: begin
            if (!run) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dec_cnt    <= '0;
         smpl_cnt   <= '0;
         post_cnt   <= '0;
         trig_seen  <= 1'b0;
         armed      <= 1'b0;
         waddr      <= '0;
         start_addr <= '0;
      end else begin
         state      <= state_d;
         dec_cnt    <= dec_cnt_d;
         smpl_cnt   <= smpl_cnt_d;
         post_cnt   <= post_cnt_d;
         trig_seen  <= trig_seen_d;
         armed      <= armed_d;
         waddr      <= waddr_d;
         start_addr <= start_addr_d;
      end
   end

endmodule
